// File: rtl/bist_sequencer_if.sv
// Control/observe bundle between a BIST sequencer and its host.
// Latency: n/a (wires only).
// Backpressure: none; tick paces the run, abort preempts it.
interface bist_sequencer_if;
    logic        tick;
    logic        start;
    logic        abort;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic        ring_counter_enable;
    logic        johnson_counter_enable;
    logic        lfsr_enable;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    modport master (
        output tick, start, abort, data_in,
        input  mode, ring_counter_enable, johnson_counter_enable, lfsr_enable,
               busy, done, pass, signature
    );

    modport slave (
        input  tick, start, abort, data_in,
        output mode, ring_counter_enable, johnson_counter_enable, lfsr_enable,
               busy, done, pass, signature
    );
endinterface

// File: rtl/bist_sequencer.sv
// BIST run sequencer: steps ring/Johnson/LFSR phases and compacts data_in into a MISR.
// Latency: state and MISR update one clk after a qualifying tick; CHECK lasts one clk.
// Backpressure: tick=0 freezes the run phase; abort forces IDLE and wins over everything.
module bist_sequencer #(
    parameter int unsigned RING_CYCLES    = 16,
    parameter int unsigned JOHNSON_CYCLES = 32,
    parameter int unsigned LFSR_CYCLES    = 255,
    parameter logic [15:0] GOLDEN         = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    bist_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RING, S_JOHNSON, S_LFSR, S_CHECK, S_DONE
    } state_t;

    localparam logic [15:0] RING_LOAD    = 16'(RING_CYCLES - 1);
    localparam logic [15:0] JOHNSON_LOAD = 16'(JOHNSON_CYCLES - 1);
    localparam logic [15:0] LFSR_LOAD    = 16'(LFSR_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] sig;
    logic        pass_q;
    logic [15:0] misr_nxt;

    assign misr_nxt = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^ bus.data_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= 16'd0;
            sig    <= 16'd0;
            pass_q <= 1'b0;
        end else if (bus.abort) begin
            state  <= S_IDLE;
            pass_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state  <= S_RING;
                        sig    <= 16'd0;
                        pass_q <= 1'b0;
                        cnt    <= RING_LOAD;
                    end
                end
                S_RING, S_JOHNSON, S_LFSR: begin
                    if (bus.tick) begin
                        sig <= misr_nxt;
                        if (cnt != 16'd0) begin
                            cnt <= cnt - 16'd1;
                        end else begin
                            // Counter hit zero on this tick: hand over to the next phase.
                            case (state)
                                S_RING: begin
                                    state <= S_JOHNSON;
                                    cnt   <= JOHNSON_LOAD;
                                end
                                S_JOHNSON: begin
                                    state <= S_LFSR;
                                    cnt   <= LFSR_LOAD;
                                end
                                default: state <= S_CHECK;
                            endcase
                        end
                    end
                end
                S_CHECK: begin
                    pass_q <= (sig == GOLDEN);
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mode = 2'b00;
        case (state)
            S_RING:    bus.mode = 2'b01;
            S_JOHNSON: bus.mode = 2'b10;
            S_LFSR:    bus.mode = 2'b11;
            default:   bus.mode = 2'b00;
        endcase
    end

    assign bus.ring_counter_enable    = (state == S_RING);
    assign bus.johnson_counter_enable = (state == S_JOHNSON);
    assign bus.lfsr_enable            = (state == S_LFSR);
    assign bus.busy      = (state == S_RING) || (state == S_JOHNSON) ||
                           (state == S_LFSR) || (state == S_CHECK);
    assign bus.done      = (state == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: random and directed runs against a tick-count reference model.
// Latency: outputs sampled 1 ns after each rising clk edge.
// Backpressure: tick gaps and aborts are injected by the stimulus.
module tb_bist_sequencer;
    localparam int R = 3;
    localparam int J = 4;
    localparam int L = 5;
    localparam logic [15:0] G = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bist_sequencer_if bm ();
    bist_sequencer_if b2 ();
    bist_sequencer_if b1 ();

    bist_sequencer #(.RING_CYCLES(R), .JOHNSON_CYCLES(J), .LFSR_CYCLES(L), .GOLDEN(G))
        dut (.clk(clk), .rst(rst), .bus(bm));
    bist_sequencer #(.RING_CYCLES(2), .JOHNSON_CYCLES(2), .LFSR_CYCLES(2), .GOLDEN(16'h0000))
        dut2 (.clk(clk), .rst(rst), .bus(b2));
    bist_sequencer #(.RING_CYCLES(1), .JOHNSON_CYCLES(1), .LFSR_CYCLES(1), .GOLDEN(16'h0000))
        dut1 (.clk(clk), .rst(rst), .bus(b1));

    int n_chk = 0;
    int n_err = 0;

    // Model: 0 idle, 1 running, 2 check, 3 done; m_t counts ticks consumed in this run.
    int          m_st   = 0;
    int          m_t    = 0;
    logic [15:0] m_sig  = 16'h0000;
    logic        m_pass = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ d;
    endfunction

    function automatic logic [1:0] phase(input int t);
        if (t < R) return 2'b01;
        if (t < R + J) return 2'b10;
        return 2'b11;
    endfunction

    task automatic model_step();
        if (bm.abort) begin
            m_st   = 0;
            m_pass = 1'b0;
        end else if (m_st == 0 || m_st == 3) begin
            if (bm.start) begin
                m_st = 1; m_t = 0; m_sig = 16'h0000; m_pass = 1'b0;
            end
        end else if (m_st == 1) begin
            if (bm.tick) begin
                m_sig = misr(m_sig, bm.data_in);
                m_t++;
                if (m_t == R + J + L) m_st = 2;
            end
        end else begin
            m_pass = (m_sig == G);
            m_st   = 3;
        end
    endtask

    task automatic check_main();
        logic [1:0] em;
        logic [7:0] ectl, octl;
        em   = (m_st == 1) ? phase(m_t) : 2'b00;
        ectl = {em, em == 2'b01, em == 2'b10, em == 2'b11,
                (m_st == 1 || m_st == 2), m_st == 3, m_pass};
        octl = {bm.mode, bm.ring_counter_enable, bm.johnson_counter_enable, bm.lfsr_enable,
                bm.busy, bm.done, bm.pass};
        chk("ctl", {24'd0, octl}, {24'd0, ectl});
        chk("sig", {16'd0, bm.signature}, {16'd0, m_sig});
    endtask

    task automatic cyc(input logic t, input logic s, input logic a, input logic [15:0] d);
        bm.tick = t; bm.start = s; bm.abort = a; bm.data_in = d;
        @(posedge clk);
        model_step();
        #1;
        check_main();
    endtask

    logic [15:0] pat [R+J+L];

    // Full run from IDLE/DONE; optional 5-clk tick gap once gap_at ticks have been consumed.
    task automatic run_seq(input int gap_at, output int cycles, output logic [15:0] s);
        int k = 0;
        int gap = (gap_at >= 0) ? 5 : 0;
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cycles = 0;
        while (!bm.done && cycles < 100) begin
            if (k == gap_at && gap > 0) begin
                cyc(1'b0, 1'b0, 1'b0, 16'($urandom));
                gap--;
            end else begin
                cyc(1'b1, 1'b0, 1'b0, (k < R + J + L) ? pat[k] : 16'h0);
                k++;
            end
            cycles++;
        end
        if (cycles >= 100) chk("run_timeout", 32'(cycles), 32'd0);
        s = bm.signature;
    endtask

    initial begin
        int          ca, cb;
        logic [15:0] sa, sb;
        int          m2 [7] = '{1, 1, 2, 2, 3, 3, 0};
        logic [15:0] s1 [4] = '{16'h0000, 16'h0001, 16'h0003, 16'h0007};
        int          m1 [4] = '{1, 2, 3, 0};

        {bm.tick, bm.start, bm.abort, bm.data_in} = '0;
        {b2.tick, b2.start, b2.abort, b2.data_in} = '0;
        {b1.tick, b1.start, b1.abort, b1.data_in} = '0;
        #12;
        check_main();
        @(negedge clk) rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'h1234);

        // Zero data with GOLDEN=0 must pass.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (R + J + L + 1) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("zero_done", 32'(bm.done), 32'd1);
        chk("zero_pass", 32'(bm.pass), 32'd1);

        // Tick gating mid-JOHNSON delays completion by exactly 5 clks, same signature.
        foreach (pat[i]) pat[i] = 16'($urandom);
        run_seq(-1, ca, sa);
        chk("run_len", 32'(ca), 32'(R + J + L + 1));
        run_seq(R + 1, cb, sb);
        chk("gap_len", 32'(cb), 32'(ca + 5));
        chk("gap_sig", {16'd0, sb}, {16'd0, sa});

        // Start while busy is ignored; abort in JOHNSON; start+abort together stays IDLE.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (R + 1) cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        cyc(1'b1, 1'b0, 1'b1, 16'h5555);
        chk("abort_busy", 32'(bm.busy), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 16'h0);
        chk("abort_start_mode", 32'(bm.mode), 32'd0);

        // Asynchronous reset mid-LFSR.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (R + J + 1) cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
        #3 rst = 1'b0;
        m_st = 0; m_t = 0; m_sig = 16'h0000; m_pass = 1'b0;
        #1;
        check_main();
        @(negedge clk) rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'hffff);

        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 50) == 0,
                (($urandom % 4) == 0) ? 16'h0 : 16'($urandom));

        // All phases 2 ticks, zero data.
        b2.tick = 1'b1; b2.start = 1'b1;
        @(posedge clk); #1;
        b2.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("d2_mode", 32'(b2.mode), 32'(m2[i]));
            chk("d2_busy", 32'(b2.busy), 32'd1);
            @(posedge clk); #1;
        end
        chk("d2_done", 32'(b2.done), 32'd1);
        chk("d2_pass", 32'(b2.pass), 32'd1);
        chk("d2_sig", 32'(b2.signature), 32'h0000);

        // All phases 1 tick, data_in=1 gives a failing signature.
        b1.tick = 1'b1; b1.data_in = 16'h0001; b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("d1_sig", 32'(b1.signature), 32'(s1[i]));
            chk("d1_mode", 32'(b1.mode), 32'(m1[i]));
            @(posedge clk); #1;
        end
        chk("d1_done", 32'(b1.done), 32'd1);
        chk("d1_pass", 32'(b1.pass), 32'd0);
        chk("d1_sig_end", 32'(b1.signature), 32'h0007);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 The block SHALL have parameter RING_CYCLES, default 16, giving the number of ticks spent in the ring phase (legal range 1..65535).
REQ-002 The block SHALL have parameter JOHNSON_CYCLES, default 32, giving the number of ticks spent in the Johnson phase (legal range 1..65535).
REQ-003 The block SHALL have parameter LFSR_CYCLES, default 255, giving the number of ticks spent in the LFSR phase (legal range 1..65535).
REQ-004 The block SHALL have parameter GOLDEN, default 16'h0000, giving the expected final signature.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 tick  input  1  step enable, one-clk pulse at the datapath step rate.
REQ-008 start  input  1  level sampled each clk; requests a full test run.
REQ-009 abort  input  1  level sampled each clk; terminates any run.
REQ-010 data_in  input  16  datapath pattern output to be compacted.
REQ-011 mode  output  2  datapath mode select: 00 off, 01 ring, 10 Johnson, 11 LFSR.
REQ-012 ring_counter_enable  output  1  high only in state RING.
REQ-013 johnson_counter_enable  output  1  high only in state JOHNSON.
REQ-014 lfsr_enable  output  1  high only in state LFSR.
REQ-015 busy  output  1  high in RING, JOHNSON, LFSR and CHECK.
REQ-016 done  output  1  high only in state DONE.
REQ-017 pass  output  1  compare result; valid while done is high.
REQ-018 signature  output  16  current MISR contents.

Function
REQ-019 The FSM SHALL have the states IDLE, RING, JOHNSON, LFSR, CHECK and DONE; all outputs are registered or are decoded from the state register only.
REQ-020 When in IDLE or DONE with start=1 and abort=0, the FSM SHALL go to RING on the next clk, clear signature to 0, clear pass, and load the phase counter with RING_CYCLES-1.
REQ-021 When in RING, JOHNSON or LFSR with tick=1, the block SHALL update signature to {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} XOR data_in.
REQ-022 In the same tick, if the counter is nonzero, the block SHALL decrement it.
REQ-023 In the same tick, if the counter is 0, the FSM SHALL advance RING->JOHNSON (load JOHNSON_CYCLES-1), JOHNSON->LFSR (load LFSR_CYCLES-1) or LFSR->CHECK.
REQ-024 While tick=0 in a run phase, the block SHALL hold state, counter and signature unchanged.
REQ-025 CHECK SHALL last exactly one clk, register pass = (signature == GOLDEN), then go to DONE.
REQ-026 DONE SHALL hold pass and signature until the next accepted start or abort.
REQ-027 The block SHALL ignore start in RING, JOHNSON, LFSR and CHECK.
REQ-028 When abort=1 in any state, the FSM SHALL go to IDLE on the next clk, clear pass, and hold signature unchanged; abort SHALL take precedence over start and tick.
REQ-029 mode SHALL be 01/10/11 in RING/JOHNSON/LFSR respectively and 00 in all other states, and SHALL change in the same clk as the enables.
REQ-030 At most one of the three enables SHALL be high in any clk.
REQ-031 Total run length with tick held high SHALL be RING_CYCLES+JOHNSON_CYCLES+LFSR_CYCLES+1 clks from the first RING clk to the first DONE clk.

Reset
REQ-032 On rst=0 the block SHALL asynchronously enter IDLE and drive mode=00, all enables=0, busy=0, done=0, pass=0, signature=16'h0000 and counter=0.
REQ-033 The block SHALL leave reset on the first rising clk edge after rst rises and SHALL not start a run unless start is sampled high on that edge or later.
REQ-034 When rst is asserted mid-run, the block SHALL abandon the run with no completion state retained.

Verification
REQ-035 Reset scenario: assert rst=0 mid-LFSR -> all outputs go to their reset values immediately, without waiting for a clk edge.
REQ-036 Zero-data pass scenario: all CYCLES=2, GOLDEN=0, tick=1, data_in=0, start pulsed -> RING for 2 clks, JOHNSON for 2, LFSR for 2, CHECK for 1, then DONE with pass=1 and signature=16'h0000.
REQ-037 Fail scenario: all CYCLES=1, GOLDEN=0, tick=1, data_in=16'h0001 -> signature 0001, then 0003, then 0007; done=1 and pass=0.
REQ-038 Tick gating scenario: tick low for 5 clks mid-JOHNSON -> state, mode=10 and signature are frozen; the run completes 5 clks late with an identical signature.
REQ-039 Abort scenario: abort during JOHNSON -> IDLE next clk with enables=0, busy=0 and pass=0; a start and abort in the same clk leaves the block in IDLE.
REQ-040 Restart scenario: start while busy -> ignored; start in DONE -> RING on the next clk with signature cleared and done=0.
